touch_feedback: RTL and testbench

Haptic/buzzer feedback driver for the touch side module: consumes the combined `touched` level produced by the touch sensor front end and drives a vibration motor (or buzzer) pin with a fixed burst of on/off pulses. It sits after the touch sensor front end, in the same clock domain. It gives the user physical confirmation that a two-sensor touch was registered. It reports `busy` while a burst is playing and a one-cycle `done` when a burst completes.

---
 rtl/touch_feedback.sv | 151 +++++++++++++++
 tb/tb_touch_feedback.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/touch_feedback.sv
// touch_feedback
//   Haptic/buzzer burst driver. A rising edge on the combined touch level (while enabled)
//   plays a burst of PULSES on-pulses of ON_CYCLES each, separated by OFF_CYCLES gaps,
//   with no trailing gap after the last pulse.
//
// Build option:
//   TOUCH_FEEDBACK_RETRIGGER_EN  defined   -> a rise during a burst restarts it (no done for
//                                             the abandoned burst)
//                                undefined -> rises while busy are ignored
//
// Ports:
//   i_clk      system clock
//   i_rst      asynchronous, active-high reset
//   i_en       feedback enable; low ignores touches and aborts a running burst
//   i_touched  combined touch level, synchronous to i_clk
//   o_motor    registered motor/buzzer drive, high = on
//   o_busy     high while a burst is in progress
//   o_done     one-cycle pulse when a burst completes normally

module touch_feedback #(
    parameter int unsigned ON_CYCLES  = 5_000_000,
    parameter int unsigned OFF_CYCLES = 5_000_000,
    parameter int unsigned PULSES     = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_touched,
    output logic o_motor,
    output logic o_busy,
    output logic o_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [31:0] ON_LAST    = 32'(ON_CYCLES - 1);
    localparam logic [31:0] OFF_LAST   = 32'(OFF_CYCLES - 1);
    localparam logic [7:0]  PULSE_LAST = 8'(PULSES - 1);

    logic [1:0]  r_state;
    logic [31:0] r_phase;
    logic [7:0]  r_pulse;
    logic        r_touched_d;
    logic        r_motor;
    logic        r_busy;
    logic        r_done;

    logic [1:0]  w_state_next;
    logic [31:0] w_phase_next;
    logic [7:0]  w_pulse_next;
    logic        w_done_next;
    logic        w_rise;

    // touched_d resets high so a level already asserted out of reset is not an edge.
    assign w_rise = i_touched & ~r_touched_d & i_en;

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_pulse_next = r_pulse;
        w_done_next  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_next = ST_ON;
                    w_phase_next = '0;
                    w_pulse_next = '0;
                end
            end

            ST_ON: begin
                if (!i_en) begin
                    w_state_next = ST_IDLE;
                    w_phase_next = '0;
                    w_pulse_next = '0;
                end else if (r_phase == ON_LAST) begin
                    w_phase_next = '0;
                    if (r_pulse == PULSE_LAST) begin
                        w_state_next = ST_IDLE;
                        w_pulse_next = '0;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next = ST_GAP;
                        w_pulse_next = r_pulse + 8'd1;
                    end
                end else begin
                    w_phase_next = r_phase + 32'd1;
                end
            end

            ST_GAP: begin
                if (!i_en) begin
                    w_state_next = ST_IDLE;
                    w_phase_next = '0;
                    w_pulse_next = '0;
                end else if (r_phase == OFF_LAST) begin
                    w_state_next = ST_ON;
                    w_phase_next = '0;
                end else begin
                    w_phase_next = r_phase + 32'd1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_phase_next = '0;
                w_pulse_next = '0;
            end
        endcase

`ifdef TOUCH_FEEDBACK_RETRIGGER_EN
        // A fresh touch mid-burst (including on the completion edge) restarts from the
        // first pulse; the abandoned burst never reports done.
        if (w_rise && (r_state != ST_IDLE)) begin
            w_state_next = ST_ON;
            w_phase_next = '0;
            w_pulse_next = '0;
            w_done_next  = 1'b0;
        end
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_phase     <= '0;
            r_pulse     <= '0;
            r_touched_d <= 1'b1;
            r_motor     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_phase     <= w_phase_next;
            r_pulse     <= w_pulse_next;
            r_touched_d <= i_touched;
            // Outputs are decoded from the next state so they change on the same edge.
            r_motor     <= (w_state_next == ST_ON);
            r_busy      <= (w_state_next != ST_IDLE);
            r_done      <= w_done_next;
        end
    end

    assign o_motor = r_motor;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule

// File: tb/tb_touch_feedback.sv
// tb_touch_feedback
//   Directed bench for touch_feedback with ON_CYCLES=4, OFF_CYCLES=3, PULSES=2.
//   Expected per-cycle (motor, busy, done) triples are queued as stimulus is applied and
//   compared one per cycle, 1 time unit after each rising edge. Cycle k is the interval
//   following the edge k at which a touch rise is sampled.

module tb_touch_feedback;

    localparam int ON    = 4;
    localparam int OFF   = 3;
    localparam int NP    = 2;
    localparam int BURST = NP * ON + (NP - 1) * OFF;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic en      = 1'b1;
    logic touched = 1'b1;
    logic motor;
    logic busy;
    logic done;

    touch_feedback #(
        .ON_CYCLES  (ON),
        .OFF_CYCLES (OFF),
        .PULSES     (NP)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_touched (touched),
        .o_motor   (motor),
        .o_busy    (busy),
        .o_done    (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic m;
        logic b;
        logic d;
    } exp_t;

    exp_t q[$];
    int   n_tests     = 0;
    int   n_fail      = 0;
    int   done_cnt    = 0;
    int   motor_rises = 0;
    logic prev_motor  = 1'b0;

    function automatic exp_t mk(input logic m, input logic b, input logic d);
        exp_t e;
        e.m = m;
        e.b = b;
        e.d = d;
        return e;
    endfunction

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) q.push_back(mk(1'b0, 1'b0, 1'b0));
    endtask

    // Burst offset t: motor is on during the first ON cycles of every ON+OFF period.
    task automatic push_burst(input int from, input int to);
        for (int t = from; t <= to; t++) q.push_back(mk((t % (ON + OFF)) < ON, 1'b1, 1'b0));
    endtask

    task automatic push_done();
        q.push_back(mk(1'b0, 1'b0, 1'b1));
    endtask

    task automatic check(input string tag, input logic obs, input logic expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s @%0t: observed %0b expected %0b", tag, $time, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs == expv) else begin
            n_fail++;
            $error("FAIL %s @%0t: observed %0d expected %0d", tag, $time, obs, expv);
        end
    endtask

    task automatic clear_counts();
        done_cnt    = 0;
        motor_rises = 0;
        prev_motor  = 1'b0;
    endtask

    task automatic run(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            n_tests++;
            assert (q.size() != 0) else begin
                n_fail++;
                $error("FAIL scoreboard_underrun @%0t: observed empty queue expected entry",
                       $time);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                check("motor", motor, e.m);
                check("busy", busy, e.b);
                check("done", done, e.d);
            end
            if (done === 1'b1) done_cnt++;
            if (motor === 1'b1 && prev_motor === 1'b0) motor_rises++;
            prev_motor = motor;
        end
    endtask

    initial begin
        // Reset with touched already high: must never fire.
        repeat (3) @(posedge clk);
        #1;
        check("rst_motor", motor, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;
        push_idle(20);
        run(20);

        // Drop and re-raise; then keep touched high for 30+ cycles -> exactly one burst.
        touched = 1'b0;
        push_idle(1);
        run(1);
        clear_counts();
        touched = 1'b1;
        push_burst(0, BURST - 1);
        push_done();
        push_idle(19);
        run(BURST + 1 + 19);
        check_int("held_done_count", done_cnt, 1);
        check_int("held_motor_pulses", motor_rises, NP);

        // Drop en during cycle 5: idle from cycle 6, no done.
        touched = 1'b0;
        push_idle(2);
        run(2);
        clear_counts();
        touched = 1'b1;
        push_burst(0, 5);
        run(6);
        en = 1'b0;
        push_idle(10);
        run(10);
        check_int("abort_done_count", done_cnt, 0);
        touched = 1'b0;
        en = 1'b1;
        push_idle(2);
        run(2);

        // Second rise sampled at edge 8 of a burst.
        clear_counts();
        touched = 1'b1;
        push_burst(0, 0);
        run(1);
        touched = 1'b0;
        push_burst(1, 7);
        run(7);
        touched = 1'b1;
`ifdef TOUCH_FEEDBACK_RETRIGGER_EN
        push_burst(0, BURST - 1);
        push_done();
        run(BURST + 1);
`else
        push_burst(8, BURST - 1);
        push_done();
        run(BURST - 8 + 1);
`endif
        push_idle(5);
        run(5);
        check_int("retrig_done_count", done_cnt, 1);
        touched = 1'b0;
        push_idle(2);
        run(2);

        // Asynchronous reset during cycle 2 of a burst.
        touched = 1'b1;
        push_burst(0, 2);
        run(3);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_motor", motor, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_done", done, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_idle(10);
        run(10);
        touched = 1'b0;
        push_idle(1);
        run(1);
        clear_counts();
        touched = 1'b1;
        push_burst(0, BURST - 1);
        push_done();
        push_idle(3);
        run(BURST + 4);
        check_int("post_rst_done_count", done_cnt, 1);
        check_int("post_rst_motor_pulses", motor_rises, NP);
        check_int("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
